sram_like_responder: RTL and testbench
======================================

Name: sram_like_responder

Overview:
- Responder (slave) end of the SRAM-like req/addr_ok/data_ok bus used by the pipeline's instruction and data ports.
- Accepts requests on the address handshake and performs writes immediately into an internal word-organised RAM.
- Snapshots read data at acceptance and returns a response on data_ok, strictly in order, a fixed number of cycles later.
- Tracks up to DEPTH outstanding requests.
- Serves as the memory model behind the fetch/mem stages, with a stall input for exercising addr_ok back-pressure.

Parameters:
- ADDR_WIDTH, 10, word-index bits of internal RAM (2^ADDR_WIDTH 32-bit words).
- LATENCY, 2, cycles from acceptance edge to data_ok (legal 1..7).
- DEPTH, 4, maximum outstanding accepted-but-unanswered requests (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid from initiator.
- wr  in  1  1 = write, 0 = read.
- size  in  2  00 byte, 01 half, 10 word; informational only, wstrb governs writes.
- wstrb  in  4  byte enables for writes.
- addr  in  32  byte address; word index = addr[ADDR_WIDTH+1:2], other bits ignored.
- wdata  in  32  write data.
- addr_stall  in  1  test control; forces addr_ok low.
- addr_ok  out  1  request accepted this cycle when req=1.
- data_ok  out  1  one-cycle response strobe, in request order.
- rdata  out  32  read data; valid only with data_ok.

Behaviour:
- Reset values: addr_ok=0, data_ok=0, rdata=0; queue emptied; occupancy count=0.
- RAM contents are not reset.
- Reset asserted mid-operation discards all outstanding entries; no data_ok is produced for them.
- addr_ok = !reset & !addr_stall & (count < DEPTH).
  - Combinational, independent of req and of same-cycle pop, so there is no req→addr_ok path.
- Accept = req & addr_ok.
- Write on accept: RAM[idx] updated at the same edge, byte lanes per wstrb; wstrb=0 is a legal no-op.
- Read on accept: RAM[idx] is read before any same-edge write and stored in the entry.
  - A read accepted the cycle after a write to the same word returns the new data.
- Entry fields: {is_write, data[31:0], age[2:0]}.
- Queue is a circular buffer of DEPTH entries with head/tail pointers that wrap modulo DEPTH.
- Age: entry age=1 at the accepting edge; increments each cycle; saturates at LATENCY.
- data_ok = head valid & head age ≥ LATENCY & !reset.
  - At most one response per cycle.
  - Head pops at the edge ending the data_ok cycle.
- Response timing:
  - Earliest data_ok is cycle T+LATENCY for a request accepted in cycle T.
  - A later entry may mature while blocked behind the head; it responds the cycle after the head pops.
- rdata = head data when data_ok & !is_write, else 0. Writes still get data_ok, with rdata=0.
- Simultaneous accept and pop: count unchanged, both pointers advance.
- Full (count=DEPTH): addr_ok=0 even if a pop occurs that cycle; it reasserts the following cycle.
- With LATENCY=1 and DEPTH≥2, continuous req sustains one accept and one data_ok per cycle.
- Initiator may drop req or change addr while addr_ok=0; no state change occurs.
- Misaligned addr and size are ignored; full word is read.

Test Plan:
- Reset, then RAM preloaded via writes: write 0x12345678 to addr 0x1c000000 (wstrb 1111), then read the same address → data_ok exactly LATENCY=2 cycles after read acceptance, rdata=0x12345678.
- Byte write: wstrb=0010, wdata=0x0000AB00 to a word holding 0x11223344 → subsequent read returns 0x1122AB44; the write's own data_ok has rdata=0.
- Pipelined reads of words holding 0,4,8,12 at LATENCY=1, req held high → 4 accepts in 4 cycles, data_ok in 4 consecutive cycles with rdata in request order.
- Full: with DEPTH=4 and 5 reads issued back-to-back → addr_ok low on the 5th until the cycle after the first data_ok pop.
- addr_stall=1 for 3 cycles with req=1 → no accept, no data_ok; on release, accepts with normal latency.
- Reset asserted while 3 reads are outstanding → no data_ok after reset; a new read returns correct RAM data, since contents are retained.

Source files
------------

// File: rtl/sram_like_responder_if.sv
// SRAM-like req/addr_ok/data_ok bus between an initiator (master) and a memory responder (slave).
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_stall;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata, addr_stall,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata, addr_stall,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_responder.sv
// Memory model responder for the SRAM-like bus: immediate writes, read snapshot at acceptance,
// in-order data_ok responses a fixed LATENCY after acceptance, up to DEPTH outstanding.
module sram_like_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_like_responder_if.slave bus
);
    localparam int unsigned WORDS = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AGE_W = 3;

    typedef struct packed {
        logic             is_write;
        logic [31:0]      data;
        logic [AGE_W-1:0] age;
    } entry_t;

    logic [31:0]      r_mem [WORDS];
    entry_t           r_q   [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_rd_word;
    logic                  w_addr_ok;
    logic                  w_accept;
    logic                  w_data_ok;
    entry_t                w_head;
    logic                  w_unused_bits;

    assign w_idx     = bus.addr[ADDR_WIDTH+1:2];
    assign w_rd_word = r_mem[w_idx];
    assign w_head    = r_q[r_head];

    // addr_ok looks only at occupancy, never at req or a same-cycle pop
    assign w_addr_ok = !reset && !bus.addr_stall && (r_count < CNT_W'(DEPTH));
    assign w_accept  = bus.req && w_addr_ok;
    assign w_data_ok = !reset && r_valid[r_head] && (w_head.age >= AGE_W'(LATENCY));

    assign bus.addr_ok = w_addr_ok;
    assign bus.data_ok = w_data_ok;
    assign bus.rdata   = (w_data_ok && !w_head.is_write) ? w_head.data : 32'h0;

    // Size and sub-word / out-of-range address bits carry no meaning for this model
    assign w_unused_bits = ^{bus.size, bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

    // Word RAM, byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (w_accept && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Outstanding-request ring: ages saturate at LATENCY, head pops on its data_ok cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && (r_q[i].age < AGE_W'(LATENCY))) begin
                    r_q[i].age <= r_q[i].age + AGE_W'(1);
                end
            end
            if (w_data_ok) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_accept) begin
                r_valid[r_tail]        <= 1'b1;
                r_q[r_tail].is_write   <= bus.wr;
                r_q[r_tail].data       <= bus.wr ? 32'h0 : w_rd_word;
                r_q[r_tail].age        <= AGE_W'(1);
                r_tail                 <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_data_ok);
        end
    end
endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: three instances (LATENCY 2, 1, 6) share one stimulus stream,
// each checked every cycle against a queue-based model plus directed literal expectations.
module tb_sram_like_responder;
    localparam int NI    = 3;
    localparam int DEPTH = 4;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 6;
    endfunction

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic        wr    = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  size  = 2'b10;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [NI-1:0] aok;
    logic [NI-1:0] dok;
    logic [31:0]   rdv [NI];

    typedef struct {
        logic        is_wr;
        logic [31:0] d;
        int          due;
    } pend_t;

    typedef struct {
        int          k;
        int          cyc;
        logic [31:0] d;
    } resp_t;

    resp_t rlog[$];
    int    acc_c [NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    generate
        for (genvar k = 0; k < NI; k++) begin : g
            localparam int unsigned L = (k == 0) ? 2 : (k == 1) ? 1 : 6;
            sram_like_responder_if bus ();
            assign bus.req        = req;
            assign bus.wr         = wr;
            assign bus.size       = size;
            assign bus.wstrb      = wstrb;
            assign bus.addr       = addr;
            assign bus.wdata      = wdata;
            assign bus.addr_stall = stall;

            sram_like_responder #(.ADDR_WIDTH(10), .LATENCY(L), .DEPTH(DEPTH)) dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus)
            );

            assign aok[k] = bus.addr_ok;
            assign dok[k] = bus.data_ok;
            assign rdv[k] = bus.rdata;

            logic [31:0] mem [1024];
            pend_t       q[$];

            // Each response is due at max(accept+L, previous response+1)
            always @(negedge clk) begin : model
                logic        e_aok, e_dok, acc;
                logic [31:0] e_rd, old;
                int          idx, due;
                e_aok = !reset && !stall && (q.size() < DEPTH);
                e_dok = !reset && (q.size() > 0) && (q[0].due <= cyc);
                e_rd  = 32'h0;
                if (e_dok && !q[0].is_wr) e_rd = q[0].d;
                chk($sformatf("i%0d_addr_ok", k), 32'(aok[k]), 32'(e_aok));
                chk($sformatf("i%0d_data_ok", k), 32'(dok[k]), 32'(e_dok));
                chk($sformatf("i%0d_rdata", k), rdv[k], e_rd);
                if (dok[k]) rlog.push_back('{k, cyc, rdv[k]});
                acc = req && e_aok;
                if (reset) begin
                    q.delete();
                end else begin
                    if (e_dok) void'(q.pop_front());
                    if (acc) begin
                        idx = int'(addr[11:2]);
                        old = mem[idx];
                        due = cyc + int'(L);
                        if (q.size() > 0 && q[$].due + 1 > due) due = q[$].due + 1;
                        q.push_back('{wr, wr ? 32'h0 : old, due});
                        if (wr) begin
                            for (int b = 0; b < 4; b++) begin
                                if (wstrb[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a request until every instance has accepted it once
    task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [NI-1:0] got;
        int n;
        got = '0;
        n   = 0;
        req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
        for (int i = 0; i < NI; i++) acc_c[i] = -1;
        while (got != {NI{1'b1}} && n < 40) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (aok[i] && !got[i]) begin
                    got[i]   = 1'b1;
                    acc_c[i] = cyc;
                end
            end
            n++;
            tick();
        end
        req = 1'b0;
        chk("op_accept", 32'(got), 32'({NI{1'b1}}));
    endtask

    task automatic expect_resp(input string name, input logic [31:0] exp);
        int found;
        repeat (12) tick();
        for (int k = 0; k < NI; k++) begin
            found = 0;
            foreach (rlog[j]) begin
                if (found == 0 && rlog[j].k == k && rlog[j].cyc > acc_c[k]) begin
                    found = 1;
                    chk($sformatf("%s_i%0d_lat", name, k), 32'(rlog[j].cyc - acc_c[k]), 32'(lat_of(k)));
                    chk($sformatf("%s_i%0d_data", name, k), rlog[j].d, exp);
                end
            end
            chk($sformatf("%s_i%0d_seen", name, k), 32'(found), 32'd1);
        end
    endtask

    initial begin
        int t0, n, cnt, rc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_ok", 32'(aok), 32'h0);
        chk("rst_data_ok", 32'(dok), 32'h0);
        chk("rst_rdata", rdv[0], 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_addr_ok", 32'(aok), 32'h7);
        tick();

        op(1'b1, 32'h1c000000, 32'h12345678, 4'hF);
        expect_resp("wr_full", 32'h0);
        op(1'b0, 32'h1c000000, 32'h0, 4'h0);
        expect_resp("rd_full", 32'h12345678);

        op(1'b1, 32'h1c000004, 32'h11223344, 4'hF);
        expect_resp("wr_base", 32'h0);
        op(1'b1, 32'h1c000004, 32'h0000AB00, 4'b0010);
        expect_resp("wr_byte", 32'h0);
        op(1'b0, 32'h1c000004, 32'h0, 4'h0);
        expect_resp("rd_byte", 32'h1122AB44);

        for (int i = 0; i < 16; i++) begin
            op(1'b1, 32'h100 + 32'(4 * i), (i < 4) ? 32'(4 * i) : $urandom, 4'hF);
        end
        repeat (12) tick();

        // Back-to-back reads with req held high
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; wr = 1'b0; addr = 32'h100 + 32'(4 * i);
            @(negedge clk);
            chk("pipe_addr_ok", 32'(aok), 32'h7);
            tick();
        end
        req = 1'b0;
        repeat (12) tick();
        for (int k = 0; k < NI; k++) begin
            cnt = 0;
            foreach (rlog[m]) begin
                if (rlog[m].k == k && rlog[m].cyc >= t0 && cnt < 4) begin
                    chk($sformatf("pipe_i%0d_cyc", k), 32'(rlog[m].cyc), 32'(t0 + lat_of(k) + cnt));
                    chk($sformatf("pipe_i%0d_data", k), rlog[m].d, 32'(4 * cnt));
                    cnt++;
                end
            end
            chk($sformatf("pipe_i%0d_count", k), 32'(cnt), 32'd4);
        end

        // Fill the LATENCY=6 instance, fifth request must wait for the first pop
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; wr = 1'b0; addr = 32'h100 + 32'(4 * i);
            @(negedge clk);
            chk("fill_addr_ok", 32'(aok[2]), 32'd1);
            tick();
        end
        addr = 32'h110;
        n = 0;
        @(negedge clk);
        while (!aok[2] && n < 20) begin
            n++;
            tick();
            @(negedge clk);
        end
        chk("full_wait_cycles", 32'(n), 32'd3);
        tick();
        req = 1'b0;
        repeat (20) tick();
        cnt = -1;
        foreach (rlog[m]) if (cnt < 0 && rlog[m].k == 2 && rlog[m].cyc >= t0) cnt = rlog[m].cyc;
        chk("full_first_data_ok", 32'(cnt), 32'(t0 + 6));

        // Stall holds off acceptance
        stall = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h104;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_addr_ok", 32'(aok), 32'h0);
            chk("stall_data_ok", 32'(dok), 32'h0);
            tick();
        end
        stall = 1'b0;
        op(1'b0, 32'h104, 32'h0, 4'h0);
        expect_resp("stall_rd", 32'h4);

        // Reset with reads in flight
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; wr = 1'b0; addr = 32'h108;
            tick();
        end
        req = 1'b0;
        reset = 1'b1;
        rc = cyc;
        tick();
        tick();
        reset = 1'b0;
        repeat (12) tick();
        cnt = 0;
        foreach (rlog[m]) if (rlog[m].cyc >= rc) cnt++;
        chk("rst_flush_no_data_ok", 32'(cnt), 32'd0);
        op(1'b0, 32'h10c, 32'h0, 4'h0);
        expect_resp("post_rst_rd", 32'hc);

        // Random traffic over the preloaded window
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom % 100) == 0;
            stall = ($urandom % 8) == 0;
            req   = ($urandom % 4) != 0;
            wr    = ($urandom % 3) == 0;
            addr  = {20'($urandom), 10'(64 + ($urandom % 16)), 2'($urandom)};
            wdata = $urandom;
            wstrb = 4'($urandom);
            size  = 2'($urandom);
            tick();
        end
        reset = 1'b0; stall = 1'b0; req = 1'b0;
        repeat (15) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
